stream_mult_q: RTL and testbench

- Pipelined fixed-point multiplier between FWFT FIFOs. Computes DEQUANTIZE(I*Q), or DEQUANTIZE(I*gain) in constant-gain mode.
- Saturates the result to DATA_WIDTH and counts saturation events.
- Sustains one result per clock, against two cycles per result for the earlier two-state multiplier.
- Sits between demod/filter stages wherever two sample streams (or a stream and a runtime gain) are multiplied.

---
 rtl/stream_mult_pkg.sv | 40 ++++
 rtl/stream_mult_q.sv | 86 ++++++++
 tb/tb_stream_mult_q.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mult_pkg.sv
// Shared types and fixed-point helpers for the streaming multiplier.
// Helpers work on a 64-bit signed carrier, so sample widths up to 32 bits are supported.
package stream_mult_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_BITS       = 10;
    localparam int QUANT_VAL      = 1 << DEF_BITS;

    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef struct packed {
        logic  valid;
        wide_t data;
    } stage_t;

    // Arithmetic shift alone floors; the bias makes negatives truncate toward zero.
    function automatic wide_t DEQUANTIZE(input wide_t p, input int bits);
        wide_t bias;
        bias = (wide_t'(1) <<< bits) - wide_t'(1);
        if (p < 0)
            return (p + bias) >>> bits;
        else
            return p >>> bits;
    endfunction

    function automatic wide_t SATURATE(input wide_t d, input int width);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (d > hi)
            return hi;
        else if (d < lo)
            return lo;
        else
            return d;
    endfunction

endpackage

// File: rtl/stream_mult_q.sv
// Three-stage I*Q (or I*gain) fixed-point multiplier between FWFT FIFOs; pop to write = 3 cycles.
// A held result under out_full freezes the whole pipeline and blocks pops; one result per clock otherwise.
module stream_mult_q
    import stream_mult_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BITS       = DEF_BITS,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] I_dout,
    input  logic                  I_empty,
    output logic                  I_rd_en,
    input  logic [DATA_WIDTH-1:0] Q_dout,
    input  logic                  Q_empty,
    output logic                  Q_rd_en,
    input  logic                  mode,
    input  logic [DATA_WIDTH-1:0] gain,
    output logic [DATA_WIDTH-1:0] out_din,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic                  sat_flag,
    output logic [CNT_WIDTH-1:0]  sat_count
);

    logic                           stall;
    logic                           pop;

    logic                           v1;
    logic signed [DATA_WIDTH-1:0]   a1;
    logic signed [DATA_WIDTH-1:0]   b1;
    logic signed [2*DATA_WIDTH-1:0] prod;

    stage_t                         s2;
    wide_t                          deq;
    wide_t                          sat;
    logic                           sat_hit;

    logic                           v3;

    assign stall = v3 & out_full;
    assign pop   = reset & ~stall & ~I_empty & (mode | ~Q_empty);

    assign I_rd_en   = pop;
    assign Q_rd_en   = pop & ~mode;
    assign out_wr_en = v3 & ~out_full;

    assign prod    = (2*DATA_WIDTH)'(a1) * (2*DATA_WIDTH)'(b1);
    assign deq     = DEQUANTIZE(s2.data, BITS);
    assign sat     = SATURATE(deq, DATA_WIDTH);
    assign sat_hit = s2.valid & (sat != deq);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            s2        <= '0;
            v3        <= 1'b0;
            out_din   <= '0;
            sat_flag  <= 1'b0;
            sat_count <= '0;
        end else if (!stall) begin
            // mode/gain are captured here so later changes never touch in-flight samples
            v1 <= pop;
            if (pop) begin
                a1 <= I_dout;
                b1 <= mode ? gain : Q_dout;
            end

            s2.valid <= v1;
            s2.data  <= wide_t'(prod);

            v3      <= s2.valid;
            out_din <= DATA_WIDTH'(sat);

            if (sat_hit) begin
                sat_flag <= 1'b1;
                if (sat_count != '1)
                    sat_count <= sat_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_stream_mult_q.sv
// Randomised and directed bench for stream_mult_q against a queue-based arithmetic model.
module tb_stream_mult_q;

    localparam int     DW    = 16;
    localparam int     CW    = 16;
    localparam longint ONE   = 1024;
    localparam longint MAXV  = 32767;
    localparam longint MINV  = -32768;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] I_dout, Q_dout, gain, out_din;
    logic          I_empty, Q_empty, I_rd_en, Q_rd_en;
    logic          mode, out_full, out_wr_en, sat_flag;
    logic [CW-1:0] sat_count;

    always #5 clock = ~clock;

    stream_mult_q #(.DATA_WIDTH(DW), .BITS(10), .CNT_WIDTH(CW)) dut (
        .clock     (clock),
        .reset     (reset),
        .I_dout    (I_dout),
        .I_empty   (I_empty),
        .I_rd_en   (I_rd_en),
        .Q_dout    (Q_dout),
        .Q_empty   (Q_empty),
        .Q_rd_en   (Q_rd_en),
        .mode      (mode),
        .gain      (gain),
        .out_din   (out_din),
        .out_full  (out_full),
        .out_wr_en (out_wr_en),
        .sat_flag  (sat_flag),
        .sat_count (sat_count)
    );

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    longint iq[$];
    longint qq[$];
    exp_t   exq[$];
    int     n_vec     = 0;
    int     n_err     = 0;
    int     sat_model = 0;

    // Plain integer arithmetic: SV division already truncates toward zero.
    function automatic exp_t model(longint a, longint b);
        exp_t   e;
        longint d;
        d     = (a * b) / ONE;
        e.sat = 1'b0;
        if (d > MAXV) begin
            d     = MAXV;
            e.sat = 1'b1;
        end else if (d < MINV) begin
            d     = MINV;
            e.sat = 1'b1;
        end
        e.val = d;
        return e;
    endfunction

    task automatic check(string tag, logic signed [63:0] got, logic signed [63:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic drive_heads();
        if (iq.size() == 0) begin I_empty = 1'b1; I_dout = '0; end
        else begin I_empty = 1'b0; I_dout = DW'(iq[0]); end
        if (qq.size() == 0) begin Q_empty = 1'b1; Q_dout = '0; end
        else begin Q_empty = 1'b0; Q_dout = DW'(qq[0]); end
    endtask

    task automatic push(longint a, longint b, bit use_q);
        iq.push_back(a);
        if (use_q) qq.push_back(b);
        drive_heads();
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic longint rnd_sample();
        logic [DW-1:0] r;
        r = DW'($urandom);
        if ($urandom_range(0, 3) != 0) r = DW'($signed(r) >>> 4);
        return longint'($signed(r));
    endfunction

    // Scoreboard: sample handshakes mid-cycle, apply their effect just after the edge.
    always begin
        logic          wr, ird, qrd, md, ofl;
        logic [DW-1:0] dout, g;
        longint        a, b;
        exp_t          e;
        @(negedge clock);
        wr = out_wr_en; ird = I_rd_en; qrd = Q_rd_en; md = mode; ofl = out_full;
        dout = out_din; g = gain;
        @(posedge clock);
        #1;
        if (ofl) check("write_while_full", wr, 0);
        if (wr) begin
            check("write_has_expected", exq.size() != 0, 1);
            if (exq.size() != 0) begin
                check("out_din", $signed(dout), exq[0].val);
                void'(exq.pop_front());
            end
        end
        if (ird) begin
            check("I_avail_on_pop", iq.size() != 0, 1);
            if (iq.size() != 0) begin
                a = iq.pop_front();
                b = 0;
                if (md) begin
                    check("Q_rd_in_gain_mode", qrd, 0);
                    b = longint'($signed(g));
                end else begin
                    check("Q_rd_paired", qrd, 1);
                    check("Q_avail_on_pop", qq.size() != 0, 1);
                    if (qq.size() != 0) b = qq.pop_front();
                end
                e = model(a, b);
                exq.push_back(e);
                if (e.sat && sat_model < 65535) sat_model++;
            end
        end else begin
            check("Q_rd_without_I", qrd, 0);
        end
        drive_heads();
    end

    initial begin
        longint rtz_exp [3];
        exp_t   e_first;
        longint a0, b0;

        mode = 1'b0; gain = '0; out_full = 1'b0; reset = 1'b0;
        drive_heads();
        repeat (2) tick();

        check("rst_out_din",   $signed(out_din), 0);
        check("rst_out_wr_en", out_wr_en, 0);
        check("rst_sat_flag",  sat_flag, 0);
        check("rst_sat_count", sat_count, 0);
        reset = 1'b1;
        tick();

        // Basic product with latency
        push(2048, 3072, 1);
        #1;
        check("basic_I_rd", I_rd_en, 1);
        check("basic_Q_rd", Q_rd_en, 1);
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            check("basic_wr_timing", out_wr_en, c == 3);
            if (c == 3) check("basic_out_din", $signed(out_din), 6144);
        end
        check("basic_sat_count", sat_count, 0);
        tick();

        // Round toward zero, back-to-back
        rtz_exp[0] = 0; rtz_exp[1] = -1536; rtz_exp[2] = -1024;
        push(-1, 1, 1); push(-1536, 1024, 1); push(1024, -1024, 1);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("rtz_wr_timing", out_wr_en, c >= 3);
            if (c >= 3) check("rtz_out_din", $signed(out_din), rtz_exp[c-3]);
            tick();
        end

        // Saturation both ways
        push(32767, 32767, 1); push(-32768, 32767, 1);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (c == 3) check("sat_pos", $signed(out_din), 32767);
            if (c == 4) check("sat_neg", $signed(out_din), -32768);
            tick();
        end
        check("sat_count_two", sat_count, 2);
        check("sat_flag_set",  sat_flag, 1);

        // Constant-gain mode, Q FIFO empty
        mode = 1'b1; gain = 16'd512;
        push(1000, 0, 0); push(-1000, 0, 0);
        for (int c = 0; c < 6; c++) begin
            #1;
            check("gain_Q_rd", Q_rd_en, 0);
            if (c == 3) check("gain_out0", $signed(out_din), 500);
            if (c == 4) check("gain_out1", $signed(out_din), -500);
            tick();
        end
        mode = 1'b0;

        // Back-pressure: whole pipeline freezes while out_full holds a result
        for (int k = 0; k < 5; k++) push(rnd_sample(), rnd_sample(), 1);
        for (int c = 0; c < 14; c++) begin
            out_full = (c >= 4 && c <= 9);
            #1;
            if (out_full) begin
                check("bp_no_I_rd", I_rd_en, 0);
                check("bp_no_wr",   out_wr_en, 0);
                if (exq.size() != 0) check("bp_out_stable", $signed(out_din), exq[0].val);
            end
            tick();
        end
        out_full = 1'b0;
        repeat (2) tick();
        check("bp_all_delivered", exq.size() + iq.size(), 0);

        // Reset mid-stream
        push(rnd_sample(), rnd_sample(), 1); push(rnd_sample(), rnd_sample(), 1);
        tick(); tick();
        reset = 1'b0;
        exq.delete();
        sat_model = 0;
        #1;
        check("mrst_wr",        out_wr_en, 0);
        check("mrst_I_rd",      I_rd_en, 0);
        check("mrst_out_din",   $signed(out_din), 0);
        check("mrst_sat_count", sat_count, 0);
        check("mrst_sat_flag",  sat_flag, 0);
        a0 = -12345; b0 = 777;
        push(a0, b0, 1);
        #1;
        check("mrst_rd_gated", I_rd_en, 0);
        tick();
        reset = 1'b1;
        e_first = model(a0, b0);
        #1;
        check("post_rst_pop", I_rd_en, 1);
        for (int c = 1; c <= 3; c++) begin
            tick(); #1;
            check("post_rst_wr", out_wr_en, c == 3);
            if (c == 3) check("post_rst_first", $signed(out_din), e_first.val);
        end
        tick();

        // Randomised traffic with mode/gain changes and random back-pressure
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 1) == 1) iq.push_back(rnd_sample());
            if ($urandom_range(0, 1) == 1) qq.push_back(rnd_sample());
            drive_heads();
            out_full = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 9) == 0) gain = DW'(rnd_sample());
            tick();
        end
        out_full = 1'b0;
        mode     = 1'b1;
        for (int k = 0; k < 600 && (iq.size() != 0 || exq.size() != 0); k++) tick();
        repeat (4) tick();
        check("rand_drained",   iq.size() + exq.size(), 0);
        check("rand_sat_count", sat_count, sat_model);
        check("rand_sat_flag",  sat_flag, sat_model != 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
